// File: rtl/reg_files.sv
// General-purpose register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data onto matching read ports.
`timescale 1ns/1ps
module reg_files #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrite,
  input  logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0]    rg_wrt_data,
  output logic [DATA_WIDTH-1:0]    read_reg1,
  output logic [DATA_WIDTH-1:0]    read_reg2
);

  // Entry 0 has no storage; it always reads as zero.
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (RegWrite) begin
      // Destinations of 0 or beyond NUM_REGS match no entry and are dropped.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (rg_wrt_dest == ADDRESS_WIDTH'(i)) regs[i] <= rg_wrt_data;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] stored_value(input logic [ADDRESS_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == ADDRESS_WIDTH'(i)) v = regs[i];
    end
    return v;
  endfunction

`ifdef REGFILE_WRITE_BYPASS_EN
  logic wr_fwd;
  assign wr_fwd = RegWrite && (rg_wrt_dest != '0) && (32'(rg_wrt_dest) < NUM_REGS);

  // Write-through hides the writeback-to-decode hazard.
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDRESS_WIDTH-1:0] idx);
    if (wr_fwd && (idx == rg_wrt_dest)) return rg_wrt_data;
    return stored_value(idx);
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDRESS_WIDTH-1:0] idx);
    return stored_value(idx);
  endfunction
`endif

  always_comb begin
    read_reg1 = '0;
    read_reg2 = '0;
    if (rst) begin
      read_reg1 = read_port(rs1);
      read_reg2 = read_port(rs2);
    end
  end

endmodule

// File: tb/tb_reg_files.sv
// Randomized self-checking bench for reg_files against an array-based reference model (32- and 16-entry builds).
`timescale 1ns/1ps
module tb_reg_files;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWrite;
  logic [AW-1:0] rg_wrt_dest, rs1, rs2;
  logic [DW-1:0] rg_wrt_data;
  logic [DW-1:0] a_rd1, a_rd2, b_rd1, b_rd2;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] m32 [32];
  logic [DW-1:0] m16 [32];

  reg_files #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(32)) u_dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .rg_wrt_dest(rg_wrt_dest),
    .rs1(rs1), .rs2(rs2), .rg_wrt_data(rg_wrt_data),
    .read_reg1(a_rd1), .read_reg2(a_rd2)
  );

  reg_files #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(16)) u_dut16 (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .rg_wrt_dest(rg_wrt_dest),
    .rs1(rs1), .rs2(rs2), .rg_wrt_data(rg_wrt_data),
    .read_reg1(b_rd1), .read_reg2(b_rd2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] idx, input int n);
    if (rst !== 1'b1) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (RegWrite && idx == rg_wrt_dest && rg_wrt_dest != 0 && int'(rg_wrt_dest) < n) return rg_wrt_data;
`endif
    if (idx == 0 || int'(idx) >= n) return '0;
    return (n == 32) ? m32[idx] : m16[idx];
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/r1_32"}, a_rd1, expect_rd(rs1, 32));
    check({tag, "/r2_32"}, a_rd2, expect_rd(rs2, 32));
    check({tag, "/r1_16"}, b_rd1, expect_rd(rs1, 16));
    check({tag, "/r2_16"}, b_rd2, expect_rd(rs2, 16));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      m32[i] = '0;
      m16[i] = '0;
    end
  endtask

  task automatic commit();
    if (rst === 1'b1 && RegWrite && rg_wrt_dest != 0) begin
      m32[rg_wrt_dest] = rg_wrt_data;
      if (int'(rg_wrt_dest) < 16) m16[rg_wrt_dest] = rg_wrt_data;
    end
  endtask

  // Check before the edge, let the edge happen, then check again just after it.
  task automatic step(input string tag);
    #1 check_all({tag, "_pre"});
    @(posedge clk);
    commit();
    #1 check_all({tag, "_post"});
  endtask

  initial begin
    rst = 1'b0; RegWrite = 1'b1; rg_wrt_dest = 5'd4; rg_wrt_data = 32'h12345678;
    rs1 = 5'd1; rs2 = 5'd4;
    clear_model();
    #1 check_all("rst_init");
    repeat (2) @(posedge clk);
    #1 check("t1_rd1", a_rd1, 32'h0);
    check("t1_rd2", a_rd2, 32'h0);

    rst = 1'b1;
    step("t2");
    check("t2_rd1", a_rd1, 32'h0);
    check("t2_rd2", a_rd2, 32'h12345678);

    rg_wrt_dest = 5'd0; rg_wrt_data = 32'hDEADBEEF; rs1 = 5'd0;
    step("t3");
    check("t3_rd1", a_rd1, 32'h0);

    rg_wrt_dest = 5'd7; rg_wrt_data = 32'hA5A5A5A5; rs1 = 5'd1; rs2 = 5'd2;
    step("t4_seed");
    rg_wrt_data = 32'h0F0F0F0F; rs1 = 5'd7; rs2 = 5'd7;
`ifdef REGFILE_WRITE_BYPASS_EN
    #1 check("t4_pre_rd1", a_rd1, 32'h0F0F0F0F);
`else
    #1 check("t4_pre_rd1", a_rd1, 32'hA5A5A5A5);
`endif
    step("t4");
    check("t4_post_rd1", a_rd1, 32'h0F0F0F0F);
    check("t4_post_rd2", a_rd2, 32'h0F0F0F0F);

    for (int i = 1; i < 32; i++) begin
      rg_wrt_dest = AW'(i); rg_wrt_data = 32'h100 + i;
      step("t5_wr");
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = AW'(i); rs2 = AW'(31 - i);
      #1 check("t5_sweep", a_rd1, (i == 0) ? 32'h0 : 32'h100 + i);
      check_all("t5_sweep");
    end

    // Asynchronous reset mid-cycle with a write pending.
    @(posedge clk);
    #2 RegWrite = 1'b1; rg_wrt_dest = 5'd3; rg_wrt_data = 32'hFFFF0000; rs1 = 5'd5; rs2 = 5'd3;
    #1 rst = 1'b0;
    clear_model();
    #0.5 check("t5_async_rd1", a_rd1, 32'h0);
    check("t5_async_rd2", a_rd2, 32'h0);
    check_all("t5_async");
    @(posedge clk);
    #1 rst = 1'b1; RegWrite = 1'b0;
    #1 check("t5_abort_rd2", a_rd2, 32'h0);
    check_all("t5_abort");

    RegWrite = 1'b1; rg_wrt_dest = 5'd9; rg_wrt_data = 32'h99; rs1 = 5'd9; rs2 = 5'd1;
    step("t6_seed");
    rg_wrt_dest = 5'd20; rg_wrt_data = 32'h55; rs1 = 5'd20; rs2 = 5'd9;
    step("t6");
    check("t6_rd1_16", b_rd1, 32'h0);
    check("t6_rd2_16", b_rd2, 32'h99);
    check("t6_rd1_32", a_rd1, 32'h55);

    repeat (400) begin
      RegWrite    = ($urandom_range(0, 3) != 0);
      rg_wrt_dest = AW'($urandom);
      rg_wrt_data = $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? rg_wrt_dest : AW'($urandom);
      rs2 = ($urandom_range(0, 3) == 0) ? rg_wrt_dest : AW'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        #1 rst = 1'b0;
        clear_model();
        #1 check_all("rnd_rst");
        #1 rst = 1'b1;
      end
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_files.md
Name: reg_files

Overview:
- Multi-ported general-purpose register file for the pipelined RISC-V style datapath.
- Provides two independent combinational read ports (rs1/rs2, decode stage) and one synchronous write port (writeback stage).
- Register 0 is hardwired to zero.
- Sits between the decode stage and writeback in the PipelineRegonly design.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports.
- ADDRESS_WIDTH, 5, width of the rs1, rs2 and rg_wrt_dest address ports.
- NUM_REGS, 32, number of architectural registers. Legal range is 2 to 2**ADDRESS_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = in reset).
- RegWrite  input  1  write enable for the write port.
- rg_wrt_dest  input  ADDRESS_WIDTH  write destination register index.
- rs1  input  ADDRESS_WIDTH  read port 1 register index.
- rs2  input  ADDRESS_WIDTH  read port 2 register index.
- rg_wrt_data  input  DATA_WIDTH  write data.
- read_reg1  output  DATA_WIDTH  contents of register rs1.
- read_reg2  output  DATA_WIDTH  contents of register rs2.

Behaviour:
- Storage: NUM_REGS entries of DATA_WIDTH bits each.
- Reset (rst=0):
  - Asynchronously clears every entry to 0, immediately on assertion and without waiting for clk.
  - While rst=0, all writes are blocked and read_reg1/read_reg2 read 0.
- Reset release: on rst 0->1, the next clk rising edge is the first edge that may write.
- Write:
  - Occurs on the rising edge of clk when rst=1, RegWrite=1, rg_wrt_dest!=0 and rg_wrt_dest<NUM_REGS.
  - The entry at rg_wrt_dest takes rg_wrt_data.
  - Write latency is 1 edge.
- Ignored writes: a write with rg_wrt_dest=0 or rg_wrt_dest>=NUM_REGS is silently dropped and no entry changes.
- Read:
  - Purely combinational with no clock latency.
  - read_regN = entry[rsN].
  - Index 0 always reads 0.
  - Any index >=NUM_REGS reads 0.
- Post-edge visibility: after a write edge, a read of that index returns the new value in the same cycle the edge completes.
- Simultaneous reads: rs1 and rs2 may address the same register or differ; each port is independent.
- Same-cycle read/write to the same index:
  - Behaviour is governed by the Optional Feature.
  - Without it, the port returns the old stored value until the edge.
- Reset mid-operation: rst falling at any time, including with RegWrite=1, aborts the pending write. The array is zeroed and that write is never performed.
- Output hygiene: no X may appear on read_reg1/read_reg2 for any in-range or out-of-range index once rst has been asserted at least once.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined:
  - Adds combinational write-through forwarding on each read port.
  - If rst=1, RegWrite=1, rg_wrt_dest==rsN, rg_wrt_dest!=0 and rg_wrt_dest<NUM_REGS, then read_regN = rg_wrt_data in the same cycle, before the edge.
  - This hides the writeback-to-decode hazard.
  - Both ports bypass independently.
  - Index 0 is never bypassed.
  - No forwarding occurs while rst=0.
- Undefined:
  - No forwarding; read ports show stored contents only.
  - The new value becomes visible only after the write edge.
- Stored-state behaviour is identical in both builds.

Test Plan:
1. rst=0, RegWrite=1, rg_wrt_dest=4, rg_wrt_data=32'h12345678, rs1=1, rs2=4, for 10 ns with edges -> read_reg1=0, read_reg2=0 (reset blocks write and bypass).
2. Release rst=1. Write reg 4 = 32'h12345678, rs1=1, rs2=4, wait one edge -> read_reg1=32'h0, read_reg2=32'h12345678.
3. RegWrite=1, rg_wrt_dest=0, rg_wrt_data=32'hDEADBEEF, edge, rs1=0 -> read_reg1=0.
4. Stored reg 7=32'hA5A5A5A5. Present RegWrite=1, rg_wrt_dest=7, rg_wrt_data=32'h0F0F0F0F, rs1=rs2=7, sample before the edge:
   - With REGFILE_WRITE_BYPASS_EN: both ports read 32'h0F0F0F0F.
   - Without it: both read 32'hA5A5A5A5.
   - After the edge: both builds read 32'h0F0F0F0F.
5. Write all regs 1..31 with value 32'h100+i, then sweep rs1/rs2 over 0..31 -> reg i reads 32'h100+i, reg 0 reads 0. Then assert rst=0 asynchronously mid-cycle -> all reads go to 0 immediately, with no clk edge needed.
6. NUM_REGS=16 build: write to index 20 (value 32'h55) is dropped. rs1=20 -> 0. Indices 1..15 are unaffected.
